// File: rtl/inst_fetch_pkg.sv
// Shared core constants and types for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ENTRY_W = ADDR_W + INST_W;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

    // One buffered fetch: PC in the upper half, instruction in the lower half.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // What the PC register does in a given cycle.
    typedef enum logic [1:0] {
        FETCH_HOLD     = 2'd0,
        FETCH_ADVANCE  = 2'd1,
        FETCH_REDIRECT = 2'd2
    } fetch_action_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: push/pop/flush, wrapping pointers, head shown combinationally.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: flush overrides both, pop needs data, push needs room
    // (a full buffer accepts a push when the head leaves in the same cycle).
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop && !empty && !flush;
        do_push = push && (!full || do_pop) && !flush;
        head    = mem[rd_ptr];
    end

    // Pointer and fill-count state; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; needs no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: registered PC, redirect handling, buffered output to decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    fetch_action_t     action;
    logic [ADDR_W-1:0] pc_next;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              buf_empty;
    logic              buf_full;
    logic              pop;

    // Decide this cycle's PC action: redirect wins, otherwise fetch if the buffer has room.
    always_comb begin
        pop = out_valid && out_ready;
        if (redirect_valid)
            action = FETCH_REDIRECT;
        else if (!buf_full || pop)
            action = FETCH_ADVANCE;
        else
            action = FETCH_HOLD;
    end

    // Next PC; the +4 wraps modulo 2^32 by plain truncation.
    always_comb begin
        case (action)
            FETCH_REDIRECT: pc_next = align_word(redirect_pc);
            FETCH_ADVANCE:  pc_next = pc + 32'd4;
            default:        pc_next = pc;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= pc_next;
    end

    // Pack the current fetch for the buffer.
    always_comb begin
        push_entry.pc   = pc;
        push_entry.inst = inst;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (action == FETCH_ADVANCE),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head_entry),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    // Present the head to decode; an empty buffer shows a NOP at PC 0.
    always_comb begin
        out_valid = !buf_empty;
        out_pc    = buf_empty ? '0 : head_entry.pc;
        out_inst  = buf_empty ? NOP_INST : head_entry.inst;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: random and directed stimulus, queue-based reference model.
module tb_inst_fetch;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int checks = 0;
    int errors = 0;

    // Reference model: expected buffer contents in order, plus the next fetch address.
    ent_t        exp_q[$];
    logic [31:0] mpc;

    // Instruction memory image: a fixed scramble of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign inst = imem(pc);

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare what the DUT presents against the scoreboard, consume on handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("pc", pc, mpc);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_inst", out_inst, exp_q[0].inst);
                if (out_ready) void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("empty_pc", out_pc, 32'h0);
                chk("empty_inst", out_inst, NOP);
            end
        end
    end

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    // The monitor has already removed any entry popped at this edge.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] tgt);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = tgt;
        @(posedge clk);
        #1;
        if (rv) begin
            exp_q.delete();
            mpc = {tgt[31:2], 2'b00};
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back('{pc: mpc, inst: imem(mpc)});
            mpc = mpc + 32'd4;
        end
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    endtask

    // Assert reset between clock edges and check it takes effect without a clock.
    task automatic mid_reset();
        cycle(1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_out_inst", out_inst, NOP);
        chk("rst_out_pc", out_pc, 32'h0);
        exp_q.delete();
        mpc = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mpc            = RST_PC;
        #2;
        chk("reset_pc", pc, RST_PC);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_pc", out_pc, 32'h0);
        chk("reset_out_inst", out_inst, NOP);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream after release.
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        // Backpressure then drain.
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        // Redirect with a full buffer, no pop.
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0103);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        // Redirect coincident with a pop on a full buffer.
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0200);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        // Wrap-around past the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        // Wrap-around under backpressure.
        cycle(1'b0, 1'b1, 32'hFFFF_FFF9);
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        rand_cycles(400);
        mid_reset();
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        rand_cycles(300);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: fetch buffer entries; legal values are 2 and 4 only.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pc, output, 32: byte address driven to the instruction memory.
REQ-007 SHALL have port inst, input, 32: little-endian word returned combinationally by the instruction memory for pc, same cycle.
REQ-008 SHALL have port redirect_valid, input, 1: branch/jump/trap redirect request.
REQ-009 SHALL have port redirect_pc, input, 32: redirect target.
REQ-010 SHALL have port out_valid, output, 1: buffered instruction available to decode.
REQ-011 SHALL have port out_ready, input, 1: decode accepts the head entry.
REQ-012 SHALL have port out_pc, output, 32: PC of the head entry.
REQ-013 SHALL have port out_inst, output, 32: instruction of the head entry.

Function
REQ-014 SHALL hold pc in a register; pc is never combinational from any input.
REQ-015 SHALL push {pc, inst} into the buffer and advance pc to pc+4 in a cycle when the buffer is not full, or is full and popped that same cycle, and redirect_valid=0.
REQ-016 SHALL hold pc and push nothing when the buffer is full and not popped.
REQ-017 SHALL pop the head on out_valid=1 and out_ready=1; out_ready is ignored while out_valid=0.
REQ-018 SHALL present the head combinationally from buffer storage: fetch-to-out_valid latency is exactly 1 cycle; sustained throughput is 1 instruction per cycle with out_ready held at 1.
REQ-019 SHALL drive out_inst=32'h0000_0013 (NOP) and out_pc=32'h0 while the buffer is empty.
REQ-020 SHALL, on redirect_valid=1, flush all buffer entries, discard the current fetch, and load pc with {redirect_pc[31:2], 2'b00}; out_valid is 0 in the following cycle.
REQ-021 SHALL give redirect priority over push and pop in the same cycle; a pop coincident with redirect still counts as accepted by decode.
REQ-022 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC + 4 gives 32'h0000_0000) with no error signalled.
REQ-023 SHALL keep out_valid, out_pc and out_inst stable while out_valid=1 and out_ready=0.
REQ-024 SHALL keep a fill count in the range 0..FIFO_DEPTH with wrapping read/write pointers; it never overflows or underflows.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously set pc=RESET_PC, count=0, both pointers to 0, out_valid=0, out_pc=32'h0 and out_inst=32'h0000_0013.
REQ-026 SHALL, on reset assertion mid-operation, discard all buffered entries; the first fetch after release is from RESET_PC.
REQ-027 SHALL release reset synchronously to clk by external synchronizer; the block assumes nothing beyond that.

Structure
REQ-028 SHALL take RESET_PC default, the NOP encoding 32'h0000_0013 and the instruction width constant from the shared core package.
REQ-029 SHALL implement the buffer as one sub-module, fetch_fifo (push/pop/flush, 64-bit entries, depth parameter); PC logic stays in inst_fetch.

Verification
REQ-030 SHALL cover reset-then-stream: release rst_n with out_ready=1 -> pc=0,4,8,... on consecutive cycles; out_pc=0 with out_valid=1 one cycle after release.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles with FIFO_DEPTH=2 -> two entries (pc 0,4) are held, pc stalls at 8, out_pc stays 0; out_ready=1 -> 0,4,8 drain in order.
REQ-032 SHALL cover redirect with a full buffer: redirect_pc=32'h0000_0103 -> next out_pc=32'h0000_0100, no stale entries emerge, and out_valid=0 for exactly 1 cycle.
REQ-033 SHALL cover redirect coincident with a pop and a full buffer -> redirect wins, the pop is consumed, and the count is 0 the next cycle.
REQ-034 SHALL cover wrap-around: redirect to 32'hFFFF_FFFC -> out_pc=32'hFFFF_FFFC followed by 32'h0000_0000.
REQ-035 SHALL cover mid-stream reset: assert rst_n=0 asynchronously between edges -> out_valid=0 and pc=RESET_PC immediately, before the next clock edge.
